data_buffer: RTL and testbench

- Synchronous single-clock FIFO data buffer. It is used in the SPI interface common blocks to stage words between the shift logic and the host side.
- The write and read strobes are rising-edge detected by default. A strobe held high for many cycles therefore performs exactly one push or pop.
- The block reports full status and a sticky overflow flag.

---
 rtl/data_buffer.sv | 103 ++++++++++
 tb/tb_data_buffer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/data_buffer.sv
// Single-clock FIFO staging words between SPI shift logic and the host side.
// Strobes are rising-edge detected; define DATA_BUFFER_LEVEL_EN for level-sensitive strobes.
module data_buffer #(
  parameter int WORD_SIZE = 8,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 write,
  input  logic                 read,
  input  logic [WORD_SIZE-1:0] data_in,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 buffer_full,
  output logic                 overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WORD_SIZE-1:0] mem [DEPTH];

  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW:0]          count_q, count_d;
  logic [WORD_SIZE-1:0] data_out_q, data_out_d;
  logic                 overflow_q, overflow_d;
  logic                 push_evt, pop_evt, push_ok, pop_ok;

`ifdef DATA_BUFFER_LEVEL_EN
  assign push_evt = write;
  assign pop_evt  = read;
`else
  logic write_q, read_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      write_q <= 1'b0;
      read_q  <= 1'b0;
    end else begin
      write_q <= write;
      read_q  <= read;
    end
  end

  assign push_evt = write & ~write_q;
  assign pop_evt  = read & ~read_q;
`endif

  // A pop in the same cycle frees a slot, so a push on a full buffer is still accepted.
  assign pop_ok  = pop_evt && (count_q != '0);
  assign push_ok = push_evt && ((count_q != FULL_CNT) || pop_ok);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    overflow_d = overflow_q;
    if (pop_ok) begin
      data_out_d = mem[rd_ptr_q];
      rd_ptr_d   = rd_ptr_q + AW'(1);
    end
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (push_evt && !push_ok) begin
      overflow_d = 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is never cleared; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

  assign data_out    = data_out_q;
  assign buffer_full = (count_q == FULL_CNT);
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_data_buffer.sv
// Directed self-checking bench for data_buffer (edge mode by default,
// level-mode scenario when DATA_BUFFER_LEVEL_EN is defined).
module tb_data_buffer;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       write = 1'b0;
  logic       read = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       buffer_full;
  logic       overflow;

  int n_cmp = 0;
  int n_err = 0;

  data_buffer #(.WORD_SIZE(8), .DEPTH(4)) dut (
    .clk(clk), .rstn(rstn), .write(write), .read(read), .data_in(data_in),
    .data_out(data_out), .buffer_full(buffer_full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  // Called at posedge+1; returns at posedge+1 with the strobe low and its edge register cleared.
  task automatic do_write(input logic [7:0] d, input int hold);
    write = 1'b1; data_in = d;
    repeat (hold) @(posedge clk);
    #1 write = 1'b0;
    @(posedge clk); #1;
    $display("write 0x%02h -> full=%0b ovf=%0b", d, buffer_full, overflow);
  endtask

  task automatic do_read(input int hold);
    read = 1'b1;
    repeat (hold) @(posedge clk);
    #1 read = 1'b0;
    @(posedge clk); #1;
    $display("read -> data_out=0x%02h full=%0b ovf=%0b", data_out, buffer_full, overflow);
  endtask

  task automatic apply_reset();
    #2 rstn = 1'b0;
    #10 rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL reset_data_out: got 0x%02h want 0x00", data_out); end
    n_cmp++; if (buffer_full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %0b want 0", buffer_full); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
    #12 rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [7:0] exp [5];
    exp[0] = 8'd51; exp[1] = 8'd14; exp[2] = 8'd128; exp[3] = 8'd128; exp[4] = 8'd128;
    do_write(8'd51, 10);
    do_write(8'd14, 10);
    do_write(8'd128, 10);
    n_cmp++; if (buffer_full !== 1'b0) begin n_err++; $display("FAIL basic_full3: got %0b want 0", buffer_full); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL basic_ovf3: got %0b want 0", overflow); end
    for (int i = 0; i < 5; i++) begin
      do_read(10);
      n_cmp++; if (data_out !== exp[i]) begin n_err++; $display("FAIL basic_read%0d: got 0x%02h want 0x%02h", i, data_out, exp[i]); end
    end
    // Empty now: one push then one pop must return exactly that word.
    do_write(8'h5A, 1);
    do_read(1);
    n_cmp++; if (data_out !== 8'h5A) begin n_err++; $display("FAIL basic_empty_after: got 0x%02h want 0x5a", data_out); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) begin
      do_write(8'hA1 + 8'(i), 3);
      n_cmp++; if (buffer_full !== (i == 3)) begin n_err++; $display("FAIL ovf_fill%0d_full: got %0b want %0b", i, buffer_full, (i == 3)); end
    end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_before: got %0b want 0", overflow); end
    do_write(8'hFF, 3);
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %0b want 1", overflow); end
    n_cmp++; if (buffer_full !== 1'b1) begin n_err++; $display("FAIL ovf_full_kept: got %0b want 1", buffer_full); end
    for (int i = 0; i < 4; i++) begin
      do_read(3);
      n_cmp++; if (data_out !== 8'hA1 + 8'(i)) begin n_err++; $display("FAIL ovf_read%0d: got 0x%02h want 0x%02h", i, data_out, 8'hA1 + 8'(i)); end
      n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky%0d: got %0b want 1", i, overflow); end
      n_cmp++; if (buffer_full !== 1'b0) begin n_err++; $display("FAIL ovf_full_drop%0d: got %0b want 0", i, buffer_full); end
    end
    apply_reset();
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_cleared: got %0b want 0", overflow); end
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp [4];
    exp[0] = 8'h20; exp[1] = 8'h30; exp[2] = 8'h40; exp[3] = 8'h55;
    do_write(8'h10, 2); do_write(8'h20, 2); do_write(8'h30, 2); do_write(8'h40, 2);
    write = 1'b1; read = 1'b1; data_in = 8'h55;
    @(posedge clk); #1;
    write = 1'b0; read = 1'b0;
    @(posedge clk); #1;
    $display("write+read 0x55 -> data_out=0x%02h full=%0b ovf=%0b", data_out, buffer_full, overflow);
    n_cmp++; if (data_out !== 8'h10) begin n_err++; $display("FAIL simul_data: got 0x%02h want 0x10", data_out); end
    n_cmp++; if (buffer_full !== 1'b1) begin n_err++; $display("FAIL simul_full: got %0b want 1", buffer_full); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL simul_ovf: got %0b want 0", overflow); end
    for (int i = 0; i < 4; i++) begin
      do_read(2);
      n_cmp++; if (data_out !== exp[i]) begin n_err++; $display("FAIL simul_drain%0d: got 0x%02h want 0x%02h", i, data_out, exp[i]); end
    end
    // Simultaneous strobes on empty: push accepted, pop ignored, no bypass.
    write = 1'b1; read = 1'b1; data_in = 8'h77;
    @(posedge clk); #1;
    write = 1'b0; read = 1'b0;
    @(posedge clk); #1;
    $display("write+read 0x77 on empty -> data_out=0x%02h", data_out);
    n_cmp++; if (data_out !== 8'h55) begin n_err++; $display("FAIL simul_empty_hold: got 0x%02h want 0x55", data_out); end
    do_read(1);
    n_cmp++; if (data_out !== 8'h77) begin n_err++; $display("FAIL simul_empty_push: got 0x%02h want 0x77", data_out); end
  endtask

  task automatic test_async_reset();
    do_write(8'h3C, 2);
    do_write(8'h01, 1); do_write(8'h02, 1); do_write(8'h03, 1); do_write(8'h04, 1);
    #3 rstn = 1'b0;
    #1;
    $display("async reset asserted -> data_out=0x%02h full=%0b ovf=%0b", data_out, buffer_full, overflow);
    n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL areset_data: got 0x%02h want 0x00", data_out); end
    n_cmp++; if (buffer_full !== 1'b0) begin n_err++; $display("FAIL areset_full: got %0b want 0", buffer_full); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL areset_ovf: got %0b want 0", overflow); end
    #8 rstn = 1'b1;
    @(posedge clk); #1;
    do_read(2);
    n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL areset_read_empty: got 0x%02h want 0x00", data_out); end
    // Strobe already high at release counts as an edge on the first clock.
    @(posedge clk); #2 rstn = 1'b0;
    write = 1'b1; data_in = 8'hC3;
    #6 rstn = 1'b1;
    @(posedge clk); #1;
    write = 1'b0;
    @(posedge clk); #1;
    do_read(1);
    n_cmp++; if (data_out !== 8'hC3) begin n_err++; $display("FAIL release_edge: got 0x%02h want 0xc3", data_out); end
  endtask

  task automatic test_level();
    write = 1'b1;
    for (int i = 0; i < 6; i++) begin
      data_in = 8'(i + 1);
      @(posedge clk); #1;
      $display("level write cycle %0d data 0x%02h -> full=%0b ovf=%0b", i + 1, data_in, buffer_full, overflow);
      n_cmp++; if (buffer_full !== (i >= 3)) begin n_err++; $display("FAIL level_full%0d: got %0b want %0b", i + 1, buffer_full, (i >= 3)); end
      n_cmp++; if (overflow !== (i >= 4)) begin n_err++; $display("FAIL level_ovf%0d: got %0b want %0b", i + 1, overflow, (i >= 4)); end
    end
    write = 1'b0; read = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      $display("level read cycle %0d -> data_out=0x%02h", i + 1, data_out);
      n_cmp++; if (data_out !== 8'((i < 4) ? i + 1 : 4)) begin n_err++; $display("FAIL level_read%0d: got 0x%02h want 0x%02h", i + 1, data_out, 8'((i < 4) ? i + 1 : 4)); end
    end
    read = 1'b0;
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL level_ovf_sticky: got %0b want 1", overflow); end
  endtask

  initial begin
    test_reset();
`ifdef DATA_BUFFER_LEVEL_EN
    test_level();
`else
    test_basic();
    test_overflow();
    test_simultaneous();
    test_async_reset();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
